// File: rtl/shift_seq_pkg.sv
// Shared shift-ALU definitions: operation encodings and the sequencer state type.
package shift_seq_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_RL  = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_RR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Request/result handshake bundle of the shift sequencer.
interface shift_seq_if;
  import shift_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        choice;
  logic [DATA_W-1:0] i0;
  logic [3:0]        shift_by;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] o;
  logic [1:0]        out_choice;
  logic              busy;

  modport master (
    output in_valid, choice, i0, shift_by, out_ready,
    input  in_ready, out_valid, o, out_choice, busy
  );

  modport slave (
    input  in_valid, choice, i0, shift_by, out_ready,
    output in_ready, out_valid, o, out_choice, busy
  );

endinterface

// File: rtl/shift_seq_shift1_step.sv
// One-position shift or rotate of a 16-bit word, selected by op.
module shift1_step
  import shift_seq_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_comb begin
    q = d;
    case (op)
      OP_SLL:  q = {d[14:0], 1'b0};
      OP_RL:   q = {d[14:0], d[15]};
      OP_SRL:  q = {1'b0, d[15:1]};
      OP_RR:   q = {d[0], d[15:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: accepts one request, steps it one position per cycle,
// then holds the result until the consumer takes it.
module shift_seq
  import shift_seq_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  shift_seq_if.slave bus
);

  state_t            state;
  logic [DATA_W-1:0] data;
  logic [3:0]        cnt;
  logic [1:0]        op_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] step_q;

  shift1_step u_step (
    .op (op_q),
    .d  (data),
    .q  (step_q)
  );

  // Handshake outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      data        <= '0;
      cnt         <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            data       <= bus.i0;
            op_q       <= bus.choice;
            cnt        <= bus.shift_by;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.shift_by == 4'd0) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data <= step_q;
          cnt  <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          // in_ready rises only after this edge, leaving one cycle between transactions.
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.o          = data;
  assign bus.out_choice = op_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: requests push reference results, completions pop and compare.
module tb_shift_seq;
  import shift_seq_pkg::*;

  typedef struct {
    logic [15:0] o;
    logic [1:0]  ch;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  shift_seq_if bus ();

  shift_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                            input logic [3:0] n);
    logic [31:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   return d << n;
      2'b01:   begin dd = dd << n; return dd[31:16]; end
      2'b10:   return d >> n;
      default: begin dd = dd >> n; return dd[15:0]; end
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] by);
    exp_t e;
    int   k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.in_ready !== 1'b1) begin
      errors++;
      checks++;
      $display("[TB] FAIL send_wait: in_ready=%b required 1 within 40 cycles", bus.in_ready);
    end
    bus.choice   = op;
    bus.i0       = d;
    bus.shift_by = by;
    bus.in_valid = 1'b1;
    e.o   = ref_shift(op, d, by);
    e.ch  = op;
    e.lat = int'(by) + 1;
    exp_q.push_back(e);
  endtask

  task automatic collect(output logic [15:0] got_o, output logic [1:0] got_ch,
                         output int got_lat, output bit timed_out);
    got_lat   = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      got_lat++;
      if (bus.out_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    got_o  = bus.o;
    got_ch = bus.out_choice;
  endtask

  task automatic release_output();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.choice    = 2'b00;
    bus.i0        = 16'h0000;
    bus.shift_by  = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_o: got %h want 0000", bus.o); end
    checks++; if (bus.out_choice !== 2'b00) begin errors++; $display("[TB] FAIL reset_out_choice: got %b want 00", bus.out_choice); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input string name, input logic [1:0] op, input logic [15:0] d,
                               input logic [3:0] by, input logic [15:0] want_o);
    logic [15:0] got_o;
    logic [1:0]  got_ch;
    int          got_lat;
    bit          to;
    exp_t        e;
    send(op, d, by);
    collect(got_o, got_ch, got_lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL %s_timeout: out_valid not seen in 40 cycles", name);
    end else begin
      checks++; if (got_o !== want_o) begin errors++; $display("[TB] FAIL %s_o: got %h want %h", name, got_o, want_o); end
      checks++; if (got_lat != e.lat) begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, got_lat, e.lat); end
      checks++; if (got_ch !== e.ch) begin errors++; $display("[TB] FAIL %s_out_choice: got %b want %b", name, got_ch, e.ch); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy: got %b want 1", name, bus.busy); end
    end
    release_output();
  endtask

  task automatic test_backpressure();
    logic [15:0] got_o;
    logic [1:0]  got_ch;
    int          got_lat;
    bit          to;
    exp_t        e;
    send(OP_SRL, 16'h8000, 4'd4);
    collect(got_o, got_ch, got_lat, to);
    e = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("[TB] FAIL bp_timeout: out_valid not seen in 40 cycles"); end
    checks++; if (got_o !== 16'h0800) begin errors++; $display("[TB] FAIL bp_o: got %h want 0800", got_o); end
    checks++; if (got_lat != e.lat) begin errors++; $display("[TB] FAIL bp_latency: got %0d want %0d", got_lat, e.lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.choice   = OP_SLL;
        bus.i0       = 16'hFFFF;
        bus.shift_by = 4'd3;
        bus.in_valid = 1'b1;
      end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.o !== 16'h0800) begin errors++; $display("[TB] FAIL bp_hold_o[%0d]: got %h want 0800", i, bus.o); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      checks++; if (bus.out_choice !== OP_SRL) begin errors++; $display("[TB] FAIL bp_hold_choice[%0d]: got %b want 10", i, bus.out_choice); end
    end
    bus.in_valid = 1'b0;
    release_output();
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_ignored[%0d]: out_valid=%b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got_o;
    logic [1:0]  got_ch;
    int          got_lat;
    bit          to;
    bit          stray;
    exp_t        e;
    send(OP_RR, 16'h1234, 4'd8);
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL rm_busy_pre: got %b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy: got %b want 0", bus.busy); end
    checks++; if (bus.o !== 16'h0000) begin errors++; $display("[TB] FAIL rm_o: got %h want 0000", bus.o); end
    checks++; if (bus.out_choice !== 2'b00) begin errors++; $display("[TB] FAIL rm_out_choice: got %b want 00", bus.out_choice); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("[TB] FAIL rm_no_result: got stray out_valid/busy want none"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(OP_RR, 16'h1234, 4'd8);
    collect(got_o, got_ch, got_lat, to);
    e = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("[TB] FAIL rm_next_timeout: out_valid not seen in 40 cycles"); end
    checks++; if (got_o !== 16'h3412) begin errors++; $display("[TB] FAIL rm_next_o: got %h want 3412", got_o); end
    checks++; if (got_lat != e.lat) begin errors++; $display("[TB] FAIL rm_next_latency: got %0d want %0d", got_lat, e.lat); end
    release_output();
  endtask

  task automatic test_back_to_back();
    logic [15:0] got_o;
    logic [1:0]  got_ch;
    int          got_lat;
    bit          to;
    exp_t        e;
    logic [1:0]  op;
    logic [15:0] d;
    logic [3:0]  by;
    for (int n = 0; n < 1000; n++) begin
      op = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      by = 4'($urandom_range(0, 15));
      send(op, d, by);
      collect(got_o, got_ch, got_lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL b2b_timeout[%0d]: out_valid not seen in 40 cycles", n);
      end else begin
        checks++; if (got_o !== e.o) begin errors++; $display("[TB] FAIL b2b_o[%0d]: op=%b i0=%h by=%0d got %h want %h", n, op, d, by, got_o, e.o); end
        checks++; if (got_ch !== e.ch) begin errors++; $display("[TB] FAIL b2b_choice[%0d]: got %b want %b", n, got_ch, e.ch); end
        checks++; if (got_lat != e.lat) begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got %0d want %0d", n, got_lat, e.lat); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_ready[%0d]: got %b want 0", n, bus.in_ready); end
      end
      release_output();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap_ready[%0d]: got %b want 1", n, bus.in_ready); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed("sll_8001_by1", OP_SLL, 16'h8001, 4'd1, 16'h0002);
    test_directed("rl_8001_by1", OP_RL, 16'h8001, 4'd1, 16'h0003);
    test_directed("rr_0001_by15", OP_RR, 16'h0001, 4'd15, 16'h0002);
    test_directed("srl_f0f0_by0", OP_SRL, 16'hF0F0, 4'd0, 16'hF0F0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
